// File: rtl/fitness_sequencer.sv
// Step-counting fitness tracker: counts steps, derives distance, tracks per-second
// activity statistics and rotates a single display value through four quantities.
module fitness_sequencer #(
  parameter int ROT_SECS   = 2,
  parameter int DIST_SHIFT = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        pulse,
  input  logic        sec_tick,
  output logic [15:0] step_count,
  output logic [15:0] distance,
  output logic [3:0]  over32,
  output logic [15:0] hi_time,
  output logic [1:0]  mode,
  output logic [15:0] disp_value,
  output logic        sat
);

  localparam int          ROT_W    = $clog2(ROT_SECS) + 1;
  localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(ROT_SECS - 1);

  localparam logic [3:0]  ELAPSED_MAX = 4'd9;
  localparam logic [5:0]  RUN_MAX     = 6'd60;
  localparam logic [7:0]  OVER_LIMIT  = 8'd32;
  localparam logic [7:0]  HI_LIMIT    = 8'd64;
  localparam logic [15:0] SAT_LIMIT   = 16'd9999;

  typedef enum logic [1:0] {
    MODE_STEPS  = 2'd0,
    MODE_DIST   = 2'd1,
    MODE_OVER32 = 2'd2,
    MODE_HI     = 2'd3
  } disp_mode_t;

  logic             prev_pulse;
  logic             prev_start;
  logic             prev_valid;   // prev_start holds a real post-reset sample
  logic [7:0]       bucket;
  logic [3:0]       elapsed;
  logic [5:0]       run;
  logic [ROT_W-1:0] rot;
  disp_mode_t       mode_q;

  logic        step_edge;
  logic        start_rise;
  logic        count_step;
  logic        tick;
  logic [7:0]  bucket_inc;
  logic [7:0]  bucket_eff;
  logic        qualify;
  logic [15:0] hi_add;
  logic [16:0] hi_sum;
  logic [15:0] hi_next;
  logic [15:0] dist_units;

  // Right after reset prev_start is 0 only because reset forced it, so a start
  // that is already high must not look like a fresh session request.
  assign step_edge  = pulse & ~prev_pulse;
  assign start_rise = start & ~prev_start & prev_valid;
  assign count_step = start & ~start_rise & step_edge;
  assign tick       = start & ~start_rise & sec_tick;

  assign bucket_inc = (bucket == 8'hFF) ? bucket : bucket + 8'd1;
  assign bucket_eff = count_step ? bucket_inc : bucket;
  assign qualify    = (bucket_eff >= HI_LIMIT);

  // NOTE: every signal assigned in always_comb gets a default first so no path
  // leaves it unassigned; a missing default infers a latch.
  always_comb begin
    hi_add = 16'd0;
    if (run == RUN_MAX - 6'd1) hi_add = 16'd60;
    else if (run == RUN_MAX)   hi_add = 16'd1;
  end

  assign hi_sum  = {1'b0, hi_time} + {1'b0, hi_add};
  assign hi_next = hi_sum[16] ? 16'hFFFF : hi_sum[15:0];

  assign dist_units = step_count >> DIST_SHIFT;
  assign distance   = dist_units * 16'd5;
  assign sat        = (step_count >= SAT_LIMIT);
  assign mode       = mode_q;

  always_comb begin
    disp_value = 16'd0;
    case (mode_q)
      MODE_STEPS:  disp_value = sat ? SAT_LIMIT : step_count;
      MODE_DIST:   disp_value = distance;
      MODE_OVER32: disp_value = {12'd0, over32};
      MODE_HI:     disp_value = hi_time;
      default:     disp_value = 16'd0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_pulse <= 1'b0;
      prev_start <= 1'b0;
      prev_valid <= 1'b0;
      step_count <= 16'd0;
      bucket     <= 8'd0;
      elapsed    <= 4'd0;
      over32     <= 4'd0;
      run        <= 6'd0;
      hi_time    <= 16'd0;
      rot        <= '0;
      mode_q     <= MODE_STEPS;
    end else begin
      prev_pulse <= pulse;
      prev_start <= start;
      prev_valid <= 1'b1;

      if (start_rise) begin
        step_count <= 16'd0;
        bucket     <= 8'd0;
        elapsed    <= 4'd0;
        over32     <= 4'd0;
        run        <= 6'd0;
        hi_time    <= 16'd0;
        rot        <= '0;
        mode_q     <= MODE_STEPS;
      end else if (start) begin
        if (count_step && step_count != 16'hFFFF)
          step_count <= step_count + 16'd1;

        if (tick) begin
          bucket <= 8'd0;

          if (elapsed < ELAPSED_MAX) begin
            elapsed <= elapsed + 4'd1;
            if (bucket_eff > OVER_LIMIT)
              over32 <= over32 + 4'd1;
          end

          if (qualify) begin
            if (run != RUN_MAX)
              run <= run + 6'd1;
            hi_time <= hi_next;
          end else begin
            run <= 6'd0;
          end

          if (rot == ROT_LAST) begin
            rot <= '0;
            case (mode_q)
              MODE_STEPS:  mode_q <= MODE_DIST;
              MODE_DIST:   mode_q <= MODE_OVER32;
              MODE_OVER32: mode_q <= MODE_HI;
              default:     mode_q <= MODE_STEPS;
            endcase
          end else begin
            rot <= rot + ROT_W'(1);
          end
        end else if (count_step) begin
          bucket <= bucket_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_fitness_sequencer.sv
// Directed self-checking bench for fitness_sequencer with default parameters.
module tb_fitness_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        pulse;
  logic        sec_tick;
  logic [15:0] step_count;
  logic [15:0] distance;
  logic [3:0]  over32;
  logic [15:0] hi_time;
  logic [1:0]  mode;
  logic [15:0] disp_value;
  logic        sat;

  int n_checks = 0;
  int n_fail   = 0;

  fitness_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pulse      (pulse),
    .sec_tick   (sec_tick),
    .step_count (step_count),
    .distance   (distance),
    .over32     (over32),
    .hi_time    (hi_time),
    .mode       (mode),
    .disp_value (disp_value),
    .sat        (sat)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    pulse = 1'b1; cyc();
    pulse = 1'b0; cyc();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic tick();
    sec_tick = 1'b1; cyc();
    sec_tick = 1'b0;
  endtask

  task automatic second(input int n);
    steps(n);
    tick();
  endtask

  task automatic begin_session();
    start = 1'b0; cyc();
    start = 1'b1; cyc();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_steps"}, step_count, 0);
    check({tag, "_dist"},  distance,   0);
    check({tag, "_over"},  over32,     0);
    check({tag, "_hi"},    hi_time,    0);
    check({tag, "_mode"},  mode,       0);
    check({tag, "_disp"},  disp_value, 0);
    check({tag, "_sat"},   sat,        0);
  endtask

  logic [1:0]  exp_mode_tbl [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
  logic [15:0] exp_disp;
  logic [1:0]  exp_mode;

  initial begin
    reset = 1'b1; start = 1'b0; pulse = 1'b0; sec_tick = 1'b0;
    cyc(); cyc();
    check_all_zero("reset");

    // Start already high when reset releases: the first cycle is not a
    // session start, so a step edge there is counted.
    start = 1'b1; cyc();
    reset = 1'b0; pulse = 1'b1; cyc();
    pulse = 1'b0; cyc();
    check("no_rise_after_reset", step_count, 1);

    // Start rise discards a coincident step edge and tick, and clears counters.
    start = 1'b0; cyc();
    start = 1'b1; pulse = 1'b1; sec_tick = 1'b1; cyc();
    pulse = 1'b0; sec_tick = 1'b0; cyc();
    check("rise_clears_steps", step_count, 0);
    check("rise_discards_tick", mode, 0);
    steps(2047);
    check("dist_2047", distance, 0);
    step();
    check("steps_2048", step_count, 2048);
    check("dist_2048", distance, 5);
    check("mode0_2048", mode, 0);
    check("disp_2048", disp_value, 2048);

    // Over-32 window: only the first 9 seconds are evaluated.
    begin_session();
    for (int s = 0; s < 3; s++) second(40);
    check("over32_3s", over32, 3);
    for (int s = 0; s < 9; s++) second(10);
    check("over32_12s", over32, 3);
    check("elapsed_sat", dut.elapsed, 9);
    second(40);
    check("over32_held", over32, 3);

    // High-activity run: 60 consecutive qualifying seconds credit 60, then +1 each.
    begin_session();
    for (int s = 0; s < 59; s++) second(64);
    check("hi_59", hi_time, 0);
    second(64);
    check("hi_60", hi_time, 60);
    second(64);
    check("hi_61", hi_time, 61);
    second(0);
    check("hi_62", hi_time, 61);
    check("run_cleared", dut.run, 0);
    second(64);
    check("run_one", dut.run, 1);
    second(63);
    check("run_63_breaks", dut.run, 0);
    check("hi_after_break", hi_time, 61);

    // Display rotation with ROT_SECS=2, plus the selected value in each mode.
    begin_session();
    for (int i = 1; i <= 8; i++) begin
      second(40);
      exp_mode = (i % 2 == 0) ? exp_mode_tbl[i/2 - 1] : exp_mode_tbl[(i+1)/2 - 1] - 2'd1;
      check($sformatf("mode_tick%0d", i), mode, exp_mode);
      case (exp_mode)
        2'd0:    exp_disp = 16'(40 * i);
        2'd1:    exp_disp = 16'(((40 * i) >> 11) * 5);
        2'd2:    exp_disp = 16'(i);
        default: exp_disp = 16'd0;
      endcase
      check($sformatf("disp_tick%0d", i), disp_value, exp_disp);
    end
    tick(); tick();
    check("mode_tick10", mode, 1);
    start = 1'b0; cyc();
    tick(); tick(); tick();
    steps(5);
    check("idle_mode", mode, 1);
    check("idle_steps", step_count, 320);
    start = 1'b1; cyc();
    check("restart_mode", mode, 0);
    check("restart_steps", step_count, 0);

    // Step edge coincident with sec_tick counts toward the closing second.
    begin_session();
    steps(32);
    pulse = 1'b1; sec_tick = 1'b1; cyc();
    pulse = 1'b0; sec_tick = 1'b0; cyc();
    check("coincident_over32", over32, 1);
    check("coincident_steps", step_count, 33);
    steps(9965);
    check("steps_9998", step_count, 9998);
    check("sat_9998", sat, 0);
    check("disp_9998", disp_value, 9998);
    step();
    check("sat_9999", sat, 1);
    check("disp_9999", disp_value, 9999);
    step();
    check("steps_10000", step_count, 10000);
    check("sat_10000", sat, 1);
    check("disp_10000", disp_value, 9999);
    check("dist_10000", distance, 20);

    // Reset mid-session beats a coincident step edge and tick.
    reset = 1'b1; pulse = 1'b1; sec_tick = 1'b1; cyc();
    reset = 1'b0; pulse = 1'b0; sec_tick = 1'b0; start = 1'b0;
    check_all_zero("midreset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
